// File: rtl/rtc_bcd_timekeeper_if.sv
// Bus bundle for rtc_bcd_timekeeper: button/load/alarm inputs and BCD display outputs.
// The master side drives the controls; the slave side is the timekeeper core.
interface rtc_bcd_timekeeper_if;
  logic       MODE;
  logic       INC;
  logic       LOAD;
  logic [7:0] LD_HH;
  logic [7:0] LD_MM;
  logic [7:0] LD_SS;
  logic       AL_SET;
  logic [7:0] AL_HH;
  logic [7:0] AL_MM;
  logic       AL_ARM;
  logic [3:0] HRM;
  logic [3:0] HRL;
  logic [3:0] MIN_M;
  logic [3:0] MIN_L;
  logic [3:0] SEC_M;
  logic [3:0] SEC_L;
  logic       SEC_PULSE;
  logic       DAY_PULSE;
  logic [1:0] ADJ_FIELD;
  logic       LOAD_ERR;
  logic       ALARM;

  modport master (
    output MODE, INC, LOAD, LD_HH, LD_MM, LD_SS, AL_SET, AL_HH, AL_MM, AL_ARM,
    input  HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L, SEC_PULSE, DAY_PULSE, ADJ_FIELD,
           LOAD_ERR, ALARM
  );

  modport slave (
    input  MODE, INC, LOAD, LD_HH, LD_MM, LD_SS, AL_SET, AL_HH, AL_MM, AL_ARM,
    output HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L, SEC_PULSE, DAY_PULSE, ADJ_FIELD,
           LOAD_ERR, ALARM
  );
endinterface

// File: rtl/rtc_bcd_timekeeper.sv
// 24-hour BCD time-of-day core with 1 Hz prescaler, MODE/INC field adjust and parallel load.
// Optional alarm compare is built when the ALARM_EN macro is defined.
module rtc_bcd_timekeeper #(
  parameter int CLKS_PER_SEC = 100000000
) (
  input logic               CLK,
  input logic               RST,
  rtc_bcd_timekeeper_if.slave bus
);

  localparam int              PW        = $clog2(CLKS_PER_SEC);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_ADJ_HR  = 2'b01,
    ST_ADJ_MIN = 2'b10,
    ST_ADJ_SEC = 2'b11
  } state_t;

  state_t        state_r, state_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [7:0]    hh_r, hh_s, mm_r, mm_s, ss_r, ss_s;
  logic          sec_pulse_r, sec_pulse_s;
  logic          day_pulse_r, day_pulse_s;
  logic          load_err_r, load_err_s;
  logic          alarm_r, alarm_s;
  logic          tick_s;

  function automatic logic hh_legal(input logic [7:0] v);
    return ((v[7:4] < 4'd2) && (v[3:0] <= 4'd9)) || ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3));
  endfunction

  function automatic logic ms_legal(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] hour_inc(input logic [7:0] v);
    if (v == 8'h23)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] ms_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Next-state, next-time and pulse decode; LOAD > MODE > INC > tick
  always_comb begin
    state_s     = state_r;
    presc_s     = presc_r;
    hh_s        = hh_r;
    mm_s        = mm_r;
    ss_s        = ss_r;
    sec_pulse_s = 1'b0;
    day_pulse_s = 1'b0;
    load_err_s  = 1'b0;
    tick_s      = (state_r == ST_RUN) && (presc_r == PRESC_MAX);
    case (state_r)
      ST_RUN: begin
        if (bus.LOAD) begin
          if (hh_legal(bus.LD_HH) && ms_legal(bus.LD_MM) && ms_legal(bus.LD_SS)) begin
            hh_s    = bus.LD_HH;
            mm_s    = bus.LD_MM;
            ss_s    = bus.LD_SS;
            presc_s = {PW{1'b0}};
          end else begin
            load_err_s = 1'b1;
          end
        end else if (bus.MODE) begin
          state_s = ST_ADJ_HR;
          presc_s = {PW{1'b0}};
        end else if (tick_s) begin
          presc_s     = {PW{1'b0}};
          sec_pulse_s = 1'b1;
          ss_s        = ms_inc(ss_r);
          if (ss_r == 8'h59) begin
            mm_s = ms_inc(mm_r);
            if (mm_r == 8'h59) begin
              hh_s        = hour_inc(hh_r);
              day_pulse_s = (hh_r == 8'h23);
            end else begin
              hh_s = hh_r;
            end
          end else begin
            mm_s = mm_r;
          end
        end else begin
          presc_s = presc_r + PW'(1'b1);
        end
      end
      ST_ADJ_HR: begin
        presc_s = {PW{1'b0}};
        if (bus.MODE)
          state_s = ST_ADJ_MIN;
        else if (bus.INC)
          hh_s = hour_inc(hh_r);
        else
          hh_s = hh_r;
      end
      ST_ADJ_MIN: begin
        presc_s = {PW{1'b0}};
        if (bus.MODE)
          state_s = ST_ADJ_SEC;
        else if (bus.INC)
          mm_s = ms_inc(mm_r);
        else
          mm_s = mm_r;
      end
      ST_ADJ_SEC: begin
        presc_s = {PW{1'b0}};
        if (bus.MODE)
          state_s = ST_RUN;
        else if (bus.INC)
          ss_s = 8'h00;
        else
          ss_s = ss_r;
      end
      default: begin
        state_s = ST_RUN;
        presc_s = {PW{1'b0}};
      end
    endcase
  end

`ifdef ALARM_EN
  logic [7:0] al_hh_r, al_mm_r;

  // Alarm time register; illegal captures are dropped
  always_ff @(posedge CLK) begin
    if (RST) begin
      al_hh_r <= 8'h00;
      al_mm_r <= 8'h00;
    end else if (bus.AL_SET && hh_legal(bus.AL_HH) && ms_legal(bus.AL_MM)) begin
      al_hh_r <= bus.AL_HH;
      al_mm_r <= bus.AL_MM;
    end else begin
      al_hh_r <= al_hh_r;
      al_mm_r <= al_mm_r;
    end
  end

  // Fires only on a seconds tick, so load and adjust into the match time stay silent
  always_comb begin
    alarm_s = sec_pulse_s && bus.AL_ARM && (ss_s == 8'h00) &&
              (hh_s == al_hh_r) && (mm_s == al_mm_r);
  end
`else
  logic unused_al_s;
  assign unused_al_s = ^{bus.AL_SET, bus.AL_HH, bus.AL_MM, bus.AL_ARM};

  // No alarm hardware in this build
  always_comb begin
    alarm_s = 1'b0;
  end
`endif

  // State, prescaler, time digits and registered pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_RUN;
      presc_r     <= {PW{1'b0}};
      hh_r        <= 8'h00;
      mm_r        <= 8'h00;
      ss_r        <= 8'h00;
      sec_pulse_r <= 1'b0;
      day_pulse_r <= 1'b0;
      load_err_r  <= 1'b0;
      alarm_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      presc_r     <= presc_s;
      hh_r        <= hh_s;
      mm_r        <= mm_s;
      ss_r        <= ss_s;
      sec_pulse_r <= sec_pulse_s;
      day_pulse_r <= day_pulse_s;
      load_err_r  <= load_err_s;
      alarm_r     <= alarm_s;
    end
  end

  assign bus.HRM       = hh_r[7:4];
  assign bus.HRL       = hh_r[3:0];
  assign bus.MIN_M     = mm_r[7:4];
  assign bus.MIN_L     = mm_r[3:0];
  assign bus.SEC_M     = ss_r[7:4];
  assign bus.SEC_L     = ss_r[3:0];
  assign bus.SEC_PULSE = sec_pulse_r;
  assign bus.DAY_PULSE = day_pulse_r;
  assign bus.ADJ_FIELD = state_r;
  assign bus.LOAD_ERR  = load_err_r;
  assign bus.ALARM     = alarm_r;

endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// Scoreboard bench for rtc_bcd_timekeeper at CLKS_PER_SEC=4: expected pulse events are queued
// by the stimulus and popped by a monitor whenever any pulse output is high.
module tb_rtc_bcd_timekeeper;
  localparam int CPS = 4;

`ifdef ALARM_EN
  localparam logic [3:0] AL_BIT = 4'b1000;
`else
  localparam logic [3:0] AL_BIT = 4'b0000;
`endif

  logic CLK = 1'b0;
  logic RST;
  rtc_bcd_timekeeper_if bus ();

  rtc_bcd_timekeeper #(.CLKS_PER_SEC(CPS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // mask bits: [3] ALARM, [2] LOAD_ERR, [1] DAY_PULSE, [0] SEC_PULSE
  typedef struct packed {
    logic [3:0]  mask;
    logic [23:0] tm;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [23:0] tm_s;
  logic [3:0]  mask_s;
  assign tm_s   = {bus.HRM, bus.HRL, bus.MIN_M, bus.MIN_L, bus.SEC_M, bus.SEC_L};
  assign mask_s = {bus.ALARM, bus.LOAD_ERR, bus.DAY_PULSE, bus.SEC_PULSE};

  // Monitor: every cycle with a pulse must match the next queued expectation
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (mask_s != 4'b0000) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got mask %b time %h, required no pulse", mask_s, tm_s);
      end else begin
        e = exp_q.pop_front();
        if (mask_s !== e.mask || tm_s !== e.tm) begin
          n_fail++;
          $display("FAIL pulse_event: got mask %b time %h, required mask %b time %h",
                   mask_s, tm_s, e.mask, e.tm);
        end
      end
    end
  end

  task automatic expect_ev(input logic [3:0] mask, input logic [23:0] tm);
    exp_t e;
    e.mask = mask;
    e.tm   = tm;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [23:0] tm, input logic [1:0] adj);
    n_cmp++;
    if (tm_s !== tm || bus.ADJ_FIELD !== adj) begin
      n_fail++;
      $display("FAIL %s: got time %h adj %b, required time %h adj %b",
               name, tm_s, bus.ADJ_FIELD, tm, adj);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.LD_HH = h;
    bus.LD_MM = m;
    bus.LD_SS = s;
    bus.LOAD  = 1'b1;
    @(negedge CLK);
    bus.LOAD  = 1'b0;
  endtask

  task automatic pulse_mode(input int n);
    for (int i = 0; i < n; i++) begin
      bus.MODE = 1'b1;
      @(negedge CLK);
      bus.MODE = 1'b0;
    end
  endtask

  task automatic hold_inc(input int n);
    bus.INC = 1'b1;
    repeat (n) @(negedge CLK);
    bus.INC = 1'b0;
  endtask

  task automatic pulse_al_set(input logic [7:0] h, input logic [7:0] m);
    bus.AL_HH  = h;
    bus.AL_MM  = m;
    bus.AL_SET = 1'b1;
    @(negedge CLK);
    bus.AL_SET = 1'b0;
  endtask

  initial begin
    RST        = 1'b1;
    bus.MODE   = 1'b0;
    bus.INC    = 1'b0;
    bus.LOAD   = 1'b0;
    bus.LD_HH  = 8'h00;
    bus.LD_MM  = 8'h00;
    bus.LD_SS  = 8'h00;
    bus.AL_SET = 1'b0;
    bus.AL_HH  = 8'h00;
    bus.AL_MM  = 8'h00;
    bus.AL_ARM = 1'b0;
    cyc(2);
    RST = 1'b0;
    check_now("reset_state", 24'h000000, 2'b00);

    // free run: one SEC_PULSE every 4 cycles
    for (int i = 1; i <= 10; i++) begin
      logic [23:0] t;
      t = {16'h0000, 4'(i / 10), 4'(i % 10)};
      expect_ev(4'b0001, t);
    end
    cyc(40);
    check_now("run_40clk", 24'h000010, 2'b00);

    // hour adjust wraps, MODE beats INC
    pulse_mode(1);
    check_now("enter_adj_hr", 24'h000010, 2'b01);
    hold_inc(25);
    check_now("hour_inc_x25", 24'h010010, 2'b01);
    bus.MODE = 1'b1;
    bus.INC  = 1'b1;
    @(negedge CLK);
    bus.MODE = 1'b0;
    bus.INC  = 1'b0;
    check_now("mode_over_inc", 24'h010010, 2'b10);
    pulse_mode(2);
    check_now("back_to_run", 24'h010010, 2'b00);

    // day rollover and hour-unit carry at 19
    expect_ev(4'b0001, 24'h235959);
    expect_ev(4'b0011, 24'h000000);
    do_load(8'h23, 8'h59, 8'h58);
    cyc(8);
    check_now("day_rollover", 24'h000000, 2'b00);
    expect_ev(4'b0001, 24'h200000);
    do_load(8'h19, 8'h59, 8'h59);
    cyc(4);
    check_now("hour_19_to_20", 24'h200000, 2'b00);

    // illegal loads rejected
    expect_ev(4'b0100, 24'h200000);
    do_load(8'h24, 8'h00, 8'h00);
    expect_ev(4'b0100, 24'h200000);
    do_load(8'h12, 8'h60, 8'h00);
    check_now("load_err_unchanged", 24'h200000, 2'b00);

    // minute adjust, LOAD ignored outside RUN
    do_load(8'h10, 8'h59, 8'h30);
    pulse_mode(2);
    check_now("enter_adj_min", 24'h105930, 2'b10);
    do_load(8'h01, 8'h02, 8'h03);
    do_load(8'h24, 8'h00, 8'h00);
    check_now("load_ignored_adj", 24'h105930, 2'b10);
    hold_inc(61);
    check_now("min_inc_x61", 24'h100030, 2'b10);
    pulse_mode(1);
    hold_inc(1);
    check_now("sec_clear", 24'h100000, 2'b11);
    pulse_mode(1);
    expect_ev(4'b0001, 24'h100001);
    cyc(3);
    check_now("no_tick_before_4", 24'h100000, 2'b00);
    cyc(1);
    check_now("tick_after_4", 24'h100001, 2'b00);

    // reset mid-adjust, load and MODE coincident with tick
    pulse_mode(3);
    check_now("enter_adj_sec", 24'h100001, 2'b11);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_now("reset_mid_adjust", 24'h000000, 2'b00);
    cyc(3);
    do_load(8'h12, 8'h34, 8'h56);
    check_now("load_beats_tick", 24'h123456, 2'b00);
    expect_ev(4'b0001, 24'h123457);
    cyc(4);
    cyc(3);
    pulse_mode(1);
    check_now("mode_beats_tick", 24'h123457, 2'b01);
    pulse_mode(3);

    // alarm armed then disarmed
    pulse_al_set(8'h07, 8'h30);
    pulse_al_set(8'h25, 8'h00);
    bus.AL_ARM = 1'b1;
    expect_ev(4'b0001 | AL_BIT, 24'h073000);
    do_load(8'h07, 8'h29, 8'h59);
    cyc(4);
    check_now("alarm_time", 24'h073000, 2'b00);
    bus.AL_ARM = 1'b0;
    expect_ev(4'b0001, 24'h073000);
    do_load(8'h07, 8'h29, 8'h59);
    cyc(4);

    cyc(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: got %0d still queued, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
